// File: rtl/kv_line_fetcher.sv
// Line-fill engine: takes one line-miss address, reads the line word by word
// (critical word first, wrapping within the line) and hands it to the cache.
module kv_line_fetcher #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_SIZE  = 4
) (
    input  logic                                 i_clk,
    input  logic                                 i_rstn,
    input  logic [ADDR_WIDTH-1:0]                i_req_addr,
    input  logic                                 i_req_valid,
    output logic                                 o_req_ready,
    output logic [LINE_SIZE-1:0][DATA_WIDTH-1:0] o_line_data,
    output logic [ADDR_WIDTH-1:0]                o_line_addr,
    output logic                                 o_line_valid,
    input  logic                                 i_line_ready,
    output logic [ADDR_WIDTH-1:0]                o_mem_addr,
    output logic                                 o_mem_valid,
    input  logic                                 i_mem_ready,
    input  logic [DATA_WIDTH-1:0]                i_mem_rdata,
    input  logic                                 i_mem_rvalid,
    output logic                                 o_mem_rready
);

    localparam int unsigned OFF_W = $clog2(LINE_SIZE);
    localparam int unsigned CNT_W = OFF_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                                state_q, state_d;
    logic [ADDR_WIDTH-1:0]                 base_q, base_d;
    logic [OFF_W-1:0]                      start_q, start_d;
    logic [CNT_W-1:0]                      issue_cnt_q, issue_cnt_d;
    logic [OFF_W-1:0]                      rcv_cnt_q, rcv_cnt_d;
    logic [LINE_SIZE-1:0][DATA_WIDTH-1:0]  line_d;
    logic [ADDR_WIDTH-1:0]                 line_addr_d;
    logic [ADDR_WIDTH-1:0]                 mem_addr_d;
    logic                                  mem_valid_d;
    logic                                  mem_rready_d;
    logic                                  req_ready_d;
    logic                                  line_valid_d;
    logic [OFF_W-1:0]                      issue_off;

    // State register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, counters, line assembly; outputs are pre-decoded from the next state
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        start_d     = start_q;
        issue_cnt_d = issue_cnt_q;
        rcv_cnt_d   = rcv_cnt_q;
        line_d      = o_line_data;
        line_addr_d = o_line_addr;

        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    base_d      = {i_req_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
                    start_d     = i_req_addr[OFF_W-1:0];
                    issue_cnt_d = '0;
                    rcv_cnt_d   = '0;
                    line_addr_d = i_req_addr;
                    state_d     = ST_FILL;
                end
            end
            ST_FILL: begin
                if (o_mem_valid && i_mem_ready) begin
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                end
                if (i_mem_rvalid) begin
                    line_d[OFF_W'(start_q + rcv_cnt_q)] = i_mem_rdata;
                    rcv_cnt_d = rcv_cnt_q + OFF_W'(1);
                    if (rcv_cnt_q == OFF_W'(LINE_SIZE - 1)) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (i_line_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        issue_off    = OFF_W'(start_d + issue_cnt_d[OFF_W-1:0]);
        mem_addr_d   = base_d | ADDR_WIDTH'(issue_off);
        mem_valid_d  = (state_d == ST_FILL) && (issue_cnt_d < CNT_W'(LINE_SIZE));
        mem_rready_d = (state_d == ST_FILL);
        req_ready_d  = (state_d == ST_IDLE);
        line_valid_d = (state_d == ST_RESP);
    end

    // Datapath and registered outputs
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            base_q       <= '0;
            start_q      <= '0;
            issue_cnt_q  <= '0;
            rcv_cnt_q    <= '0;
            o_line_data  <= '0;
            o_line_addr  <= '0;
            o_mem_addr   <= '0;
            o_mem_valid  <= 1'b0;
            o_mem_rready <= 1'b0;
            o_req_ready  <= 1'b1;
            o_line_valid <= 1'b0;
        end else begin
            base_q       <= base_d;
            start_q      <= start_d;
            issue_cnt_q  <= issue_cnt_d;
            rcv_cnt_q    <= rcv_cnt_d;
            o_line_data  <= line_d;
            o_line_addr  <= line_addr_d;
            o_mem_addr   <= mem_addr_d;
            o_mem_valid  <= mem_valid_d;
            o_mem_rready <= mem_rready_d;
            o_req_ready  <= req_ready_d;
            o_line_valid <= line_valid_d;
        end
    end

endmodule

// File: tb/tb_kv_line_fetcher.sv
// Directed bench for kv_line_fetcher with a small in-order memory responder.
module tb_kv_line_fetcher;

    logic             i_clk;
    logic             i_rstn;
    logic [31:0]      i_req_addr;
    logic             i_req_valid;
    logic             o_req_ready;
    logic [3:0][31:0] o_line_data;
    logic [31:0]      o_line_addr;
    logic             o_line_valid;
    logic             i_line_ready;
    logic [31:0]      o_mem_addr;
    logic             o_mem_valid;
    logic             i_mem_ready;
    logic [31:0]      i_mem_rdata;
    logic             i_mem_rvalid;
    logic             o_mem_rready;

    int checks = 0;
    int errors = 0;

    logic [31:0] pending[$];
    logic [31:0] issue_log[$];
    logic        tr_mvalid[64];
    logic [31:0] tr_maddr[64];
    logic        tr_rready[64];

    kv_line_fetcher #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LINE_SIZE(4)) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_req_addr   (i_req_addr),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .o_line_data  (o_line_data),
        .o_line_addr  (o_line_addr),
        .o_line_valid (o_line_valid),
        .i_line_ready (i_line_ready),
        .o_mem_addr   (o_mem_addr),
        .o_mem_valid  (o_mem_valid),
        .i_mem_ready  (i_mem_ready),
        .i_mem_rdata  (i_mem_rdata),
        .i_mem_rvalid (i_mem_rvalid),
        .o_mem_rready (o_mem_rready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'hDA7A_0000 | {16'h0000, a[15:0]};
    endfunction

    // Memory side: ready this cycle, and return the oldest outstanding word if allowed
    task automatic drive_mem(input bit rdy, input bit rv_ok);
        i_mem_ready = rdy;
        if (rv_ok && pending.size() > 0) begin
            i_mem_rvalid = 1'b1;
            i_mem_rdata  = word_of(pending[0]);
        end else begin
            i_mem_rvalid = 1'b0;
            i_mem_rdata  = '0;
        end
    endtask

    // Advance one clock, booking the handshakes that happen at that edge
    task automatic tick();
        if (i_mem_rvalid && o_mem_rready && pending.size() > 0) void'(pending.pop_front());
        if (o_mem_valid && i_mem_ready) begin
            pending.push_back(o_mem_addr);
            issue_log.push_back(o_mem_addr);
        end
        @(posedge i_clk);
        #1;
    endtask

    // Request one line and serve it; traces memory-side outputs per cycle
    task automatic run_line(input logic [31:0] addr, input int stall_idx, input int stall_len,
                            input logic [15:0] rv_pat, input int rv_len, input bit accept,
                            output int lv_cycle);
        int stall_cnt;
        int rv_idx;
        bit rdy;
        bit rv_ok;
        issue_log.delete();
        pending.delete();
        stall_cnt = 0;
        rv_idx    = 0;
        lv_cycle  = -1;
        i_req_addr   = addr;
        i_req_valid  = 1'b1;
        i_line_ready = 1'b0;
        drive_mem(1'b1, 1'b0);
        tick();
        i_req_valid = 1'b0;
        i_req_addr  = '0;
        for (int cyc = 1; cyc < 60; cyc++) begin
            tr_mvalid[cyc] = o_mem_valid;
            tr_maddr[cyc]  = o_mem_addr;
            tr_rready[cyc] = o_mem_rready;
            if (o_line_valid) begin
                lv_cycle = cyc;
                break;
            end
            rdy = 1'b1;
            if (o_mem_valid && issue_log.size() == stall_idx && stall_cnt < stall_len) begin
                rdy = 1'b0;
                stall_cnt++;
            end
            rv_ok = 1'b1;
            if (pending.size() > 0) begin
                if (rv_idx < rv_len) rv_ok = rv_pat[rv_idx];
                rv_idx++;
            end
            drive_mem(rdy, rv_ok);
            tick();
        end
        drive_mem(1'b1, 1'b0);
        if (accept && lv_cycle >= 0) begin
            i_line_ready = 1'b1;
            tick();
            i_line_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        i_rstn = 1'b0;
        i_req_addr = '0; i_req_valid = 1'b0; i_line_ready = 1'b0;
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
        repeat (3) @(posedge i_clk);
        #1;
        checks++; if (o_req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b exp 1", o_req_ready); end
        checks++; if (o_line_valid !== 1'b0) begin errors++; $display("FAIL reset_line_valid got %0b exp 0", o_line_valid); end
        checks++; if (o_mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got %0b exp 0", o_mem_valid); end
        checks++; if (o_mem_rready !== 1'b0) begin errors++; $display("FAIL reset_mem_rready got %0b exp 0", o_mem_rready); end
        checks++; if (o_line_data !== 128'h0) begin errors++; $display("FAIL reset_line_data got %0h exp 0", o_line_data); end
        checks++; if (o_mem_addr !== 32'h0 || o_line_addr !== 32'h0) begin errors++; $display("FAIL reset_addrs got mem %0h line %0h exp 0 0", o_mem_addr, o_line_addr); end
        i_rstn = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_zero_wait();
        int lv;
        run_line(32'h100, -1, 0, 16'h0, 0, 1'b1, lv);
        checks++; if (lv !== 6) begin errors++; $display("FAIL zw_line_valid_cycle got %0d exp 6", lv); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (issue_log.size() <= k || issue_log[k] !== 32'h100 + k) begin errors++; $display("FAIL zw_issue_addr%0d got %0h exp %0h", k, (issue_log.size() > k) ? issue_log[k] : 32'hFFFF_FFFF, 32'h100 + k); end
            checks++; if (o_line_data[k] !== word_of(32'h100 + k)) begin errors++; $display("FAIL zw_line_word%0d got %0h exp %0h", k, o_line_data[k], word_of(32'h100 + k)); end
        end
        checks++; if (issue_log.size() !== 4) begin errors++; $display("FAIL zw_issue_count got %0d exp 4", issue_log.size()); end
        checks++; if (o_line_addr !== 32'h100) begin errors++; $display("FAIL zw_line_addr got %0h exp 100", o_line_addr); end
        checks++; if (o_line_valid !== 1'b0 || o_req_ready !== 1'b1) begin errors++; $display("FAIL zw_after_accept got lv %0b rdy %0b exp 0 1", o_line_valid, o_req_ready); end
    endtask

    task automatic test_critical_word();
        int lv;
        logic [31:0] exp_addr[4];
        exp_addr[0] = 32'h102; exp_addr[1] = 32'h103; exp_addr[2] = 32'h100; exp_addr[3] = 32'h101;
        run_line(32'h102, -1, 0, 16'h0, 0, 1'b0, lv);
        checks++; if (lv !== 6) begin errors++; $display("FAIL cw_line_valid_cycle got %0d exp 6", lv); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (tr_maddr[k + 1] !== exp_addr[k] || tr_mvalid[k + 1] !== 1'b1) begin errors++; $display("FAIL cw_mem_addr%0d got %0h v%0b exp %0h v1", k, tr_maddr[k + 1], tr_mvalid[k + 1], exp_addr[k]); end
        end
        checks++; if (o_line_data[2] !== word_of(32'h102)) begin errors++; $display("FAIL cw_first_beat got %0h exp %0h", o_line_data[2], word_of(32'h102)); end
        checks++; if (o_line_data[1] !== word_of(32'h101)) begin errors++; $display("FAIL cw_last_beat got %0h exp %0h", o_line_data[1], word_of(32'h101)); end
        checks++; if (o_line_data[0] !== word_of(32'h100) || o_line_data[3] !== word_of(32'h103)) begin errors++; $display("FAIL cw_other_words got %0h %0h", o_line_data[0], o_line_data[3]); end
        checks++; if (o_line_addr !== 32'h102) begin errors++; $display("FAIL cw_line_addr got %0h exp 102", o_line_addr); end
        i_line_ready = 1'b1;
        tick();
        i_line_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int lv;
        run_line(32'h100, 1, 3, 16'h0, 0, 1'b1, lv);
        for (int c = 2; c <= 5; c++) begin
            checks++; if (tr_maddr[c] !== 32'h101 || tr_mvalid[c] !== 1'b1) begin errors++; $display("FAIL bp_hold_c%0d got %0h v%0b exp 101 v1", c, tr_maddr[c], tr_mvalid[c]); end
        end
        checks++; if (issue_log.size() !== 4) begin errors++; $display("FAIL bp_issue_count got %0d exp 4", issue_log.size()); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (issue_log.size() <= k || issue_log[k] !== 32'h100 + k) begin errors++; $display("FAIL bp_issue_addr%0d exp %0h", k, 32'h100 + k); end
            checks++; if (o_line_data[k] !== word_of(32'h100 + k)) begin errors++; $display("FAIL bp_line_word%0d got %0h exp %0h", k, o_line_data[k], word_of(32'h100 + k)); end
        end
        checks++; if (lv !== 9) begin errors++; $display("FAIL bp_line_valid_cycle got %0d exp 9", lv); end
    endtask

    task automatic test_cache_stall();
        int lv;
        run_line(32'h300, -1, 0, 16'h0, 0, 1'b0, lv);
        checks++; if (lv !== 6) begin errors++; $display("FAIL cs_line_valid_cycle got %0d exp 6", lv); end
        for (int s = 0; s < 5; s++) begin
            i_line_ready = 1'b0;
            i_req_valid  = 1'b1;
            i_req_addr   = 32'h400;
            tick();
            checks++; if (o_line_valid !== 1'b1 || o_req_ready !== 1'b0 || o_mem_valid !== 1'b0) begin errors++; $display("FAIL cs_ctrl_s%0d got lv %0b rdy %0b mv %0b exp 1 0 0", s, o_line_valid, o_req_ready, o_mem_valid); end
            for (int k = 0; k < 4; k++) begin
                checks++; if (o_line_data[k] !== word_of(32'h300 + k)) begin errors++; $display("FAIL cs_word%0d_s%0d got %0h exp %0h", k, s, o_line_data[k], word_of(32'h300 + k)); end
            end
        end
        i_req_valid  = 1'b0;
        i_req_addr   = '0;
        i_line_ready = 1'b1;
        tick();
        i_line_ready = 1'b0;
        checks++; if (o_line_valid !== 1'b0 || o_req_ready !== 1'b1) begin errors++; $display("FAIL cs_release got lv %0b rdy %0b exp 0 1", o_line_valid, o_req_ready); end
        checks++; if (o_line_addr !== 32'h300 || o_mem_valid !== 1'b0) begin errors++; $display("FAIL cs_ignored_req got addr %0h mv %0b exp 300 0", o_line_addr, o_mem_valid); end
    endtask

    task automatic test_bursty_returns();
        int lv;
        run_line(32'h1C1, -1, 0, 16'h0059, 7, 1'b0, lv);
        checks++; if (tr_mvalid[5] !== 1'b0 || issue_log.size() !== 4) begin errors++; $display("FAIL br_issues_done got mv %0b n %0d exp 0 4", tr_mvalid[5], issue_log.size()); end
        checks++; if (tr_rready[7] !== 1'b1 || tr_rready[8] !== 1'b1) begin errors++; $display("FAIL br_stays_fill got %0b %0b exp 1 1", tr_rready[7], tr_rready[8]); end
        checks++; if (lv !== 9) begin errors++; $display("FAIL br_line_valid_cycle got %0d exp 9", lv); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (o_line_data[k] !== word_of(32'h1C0 + k)) begin errors++; $display("FAIL br_line_word%0d got %0h exp %0h", k, o_line_data[k], word_of(32'h1C0 + k)); end
        end
        checks++; if (o_line_addr !== 32'h1C1) begin errors++; $display("FAIL br_line_addr got %0h exp 1c1", o_line_addr); end
        i_line_ready = 1'b1;
        tick();
        i_line_ready = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        int lv;
        issue_log.delete();
        pending.delete();
        i_req_addr  = 32'h180;
        i_req_valid = 1'b1;
        drive_mem(1'b1, 1'b0);
        tick();
        i_req_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            drive_mem(1'b1, 1'b1);
            tick();
        end
        i_rstn = 1'b0;
        #1;
        checks++; if (o_req_ready !== 1'b1 || o_line_valid !== 1'b0 || o_mem_valid !== 1'b0 || o_mem_rready !== 1'b0) begin errors++; $display("FAIL rm_ctrl got rdy %0b lv %0b mv %0b rr %0b exp 1 0 0 0", o_req_ready, o_line_valid, o_mem_valid, o_mem_rready); end
        checks++; if (o_line_data !== 128'h0 || o_mem_addr !== 32'h0 || o_line_addr !== 32'h0) begin errors++; $display("FAIL rm_data got %0h %0h %0h exp 0", o_line_data, o_mem_addr, o_line_addr); end
        pending.delete();
        drive_mem(1'b1, 1'b0);
        @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
        @(posedge i_clk);
        #1;
        run_line(32'h200, -1, 0, 16'h0, 0, 1'b0, lv);
        checks++; if (lv !== 6) begin errors++; $display("FAIL rm_line_valid_cycle got %0d exp 6", lv); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (o_line_data[k] !== word_of(32'h200 + k)) begin errors++; $display("FAIL rm_line_word%0d got %0h exp %0h", k, o_line_data[k], word_of(32'h200 + k)); end
        end
        checks++; if (o_line_addr !== 32'h200) begin errors++; $display("FAIL rm_line_addr got %0h exp 200", o_line_addr); end
        i_line_ready = 1'b1;
        tick();
        i_line_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_critical_word();
        test_backpressure();
        test_cache_stall();
        test_bursty_returns();
        test_reset_mid_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
